param_counter: RTL



---
 rtl/param_counter_pkg.sv | 26 ++
 rtl/param_counter_if.sv | 44 ++++
 rtl/param_counter_prescaler.sv | 31 +++
 rtl/param_counter.sv | 108 ++++++++++
 4 files changed

// File: rtl/param_counter_pkg.sv
// Shared types for param_counter: count-mode and one-shot state encodings.
// Optional snapshot capture is enabled by defining COUNTER_SNAPSHOT_EN.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2
  } cnt_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cnt_state_e;

  // Raw mode code 3 behaves exactly like wrap.
  function automatic cnt_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return CNT_SAT;
      2'd2:    return CNT_ONESHOT;
      default: return CNT_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/param_counter_if.sv
// Control/status bundle of param_counter; snap/snap_val exist only with COUNTER_SNAPSHOT_EN.
interface param_counter_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);

  logic                  en;
  logic                  clear;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic                  up;
  logic [1:0]            mode;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      cnt;
  logic                  tc;
  logic                  busy;
  logic                  done;
`ifdef COUNTER_SNAPSHOT_EN
  logic                  snap;
  logic [WIDTH-1:0]      snap_val;
`endif

`ifdef COUNTER_SNAPSHOT_EN
  modport master (
    output en, clear, load, load_val, up, mode, limit, prescale, snap,
    input  cnt, tc, busy, done, snap_val
  );
  modport slave (
    input  en, clear, load, load_val, up, mode, limit, prescale, snap,
    output cnt, tc, busy, done, snap_val
  );
`else
  modport master (
    output en, clear, load, load_val, up, mode, limit, prescale,
    input  cnt, tc, busy, done
  );
  modport slave (
    input  en, clear, load, load_val, up, mode, limit, prescale,
    output cnt, tc, busy, done
  );
`endif

endinterface

// File: rtl/param_counter_prescaler.sv
// Enable-gated prescaler: one tick every prescale+1 enabled cycles; restart zeroes the phase.
module counter_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (restart) begin
      pcnt <= '0;
    end else if (en) begin
      if (pcnt == prescale) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/param_counter.sv
// General-purpose timer/event counter: wrap, saturate and one-shot modes with prescaler and load.
// Define COUNTER_SNAPSHOT_EN to add the snap/snap_val capture register.
module param_counter
  import counter_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               PRESCALE_W = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input logic           clk,
    input logic           rst,
    param_counter_if.slave bus
);

  logic             tick;
  logic             restart;
  logic             terminal;
  logic             active;
  cnt_mode_e        mode_s;
  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_step;
  logic             tc_q;

  assign restart = bus.clear | bus.load;

  counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .restart  (restart),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  assign mode_s   = decode_mode(bus.mode);
  // ">=" so a load above limit is treated as terminal on the next tick.
  assign terminal = bus.up ? (cnt_q >= bus.limit) : (cnt_q == '0);
  assign active   = (mode_s != CNT_ONESHOT) || (state_q == ST_RUN);

  always_comb begin
    cnt_step = cnt_q;
    if (!terminal) begin
      cnt_step = bus.up ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
    end else if (mode_s == CNT_WRAP) begin
      cnt_step = bus.up ? '0 : bus.limit;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
    end else if (mode_s != CNT_ONESHOT) begin
      state_d = ST_IDLE;
    end else if (bus.load) begin
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && tick && terminal) begin
      state_d = ST_DONE;
    end
    bus.busy = (state_q == ST_RUN);
    bus.done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RESET_VAL;
      tc_q  <= 1'b0;
    end else if (bus.clear) begin
      cnt_q <= RESET_VAL;
      tc_q  <= 1'b0;
    end else if (bus.load) begin
      cnt_q <= bus.load_val;
      tc_q  <= 1'b0;
    end else if (tick && active) begin
      cnt_q <= cnt_step;
      tc_q  <= terminal;
    end else begin
      tc_q  <= 1'b0;
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.tc  = tc_q;

`ifdef COUNTER_SNAPSHOT_EN
  // Captures the pre-update count; clear deliberately leaves it alone.
  logic [WIDTH-1:0] snap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
    end else if (bus.snap) begin
      snap_q <= cnt_q;
    end
  end

  assign bus.snap_val = snap_q;
`endif

endmodule
